// File: rtl/i2c_codec_master_if.sv
// Command/response handshake and open-drain pad signals of the codec I2C master.
// "slave" is the I2C master block's view; "master" is the requester/pad side.
interface i2c_codec_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_dev_addr;
    logic       cmd_rnw;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_sub;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_ack_err;
    logic       busy;
    logic       scl_oe;
    logic       scl_i;
    logic       sda_oe;
    logic       sda_i;

    modport master (
        output cmd_valid, cmd_dev_addr, cmd_rnw, cmd_reg, cmd_sub, cmd_wdata,
        output scl_i, sda_i,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_ack_err, busy, scl_oe, sda_oe
    );

    modport slave (
        input  cmd_valid, cmd_dev_addr, cmd_rnw, cmd_reg, cmd_sub, cmd_wdata,
        input  scl_i, sda_i,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_ack_err, busy, scl_oe, sda_oe
    );
endinterface

// File: rtl/i2c_codec_master.sv
// I2C master for the audio codec control port: START, addr, reg, sub, data/read byte, STOP.
// Optional slave clock stretching: define I2C_CLK_STRETCH_EN.
module i2c_codec_master #(
    parameter int CLK_DIV = 125
) (
    input  logic               clk,
    input  logic               rst_n,
    i2c_codec_master_if.slave  bus
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_BYTE, S_ACK, S_STOP, S_DONE} state_t;

    state_t     r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic [1:0] r_q, w_q_n;
    logic [2:0] r_bit, w_bit_n;
    logic [1:0] r_idx, w_idx_n;
    logic [7:0] r_shift, w_shift_n;
    logic [7:0] r_rx, w_rx_n;
    logic       r_nack, w_nack_n;
    logic [6:0] r_dev, w_dev_n;
    logic       r_rnw, w_rnw_n;
    logic [7:0] r_reg, w_reg_n;
    logic [7:0] r_sub, w_sub_n;
    logic [7:0] r_wdata, w_wdata_n;
    logic       r_scl_oe, w_scl_oe_n;
    logic       r_sda_oe, w_sda_oe_n;
    logic [1:0] r_sda_s;
    logic       r_rsp_valid;
    logic [7:0] r_rsp_rdata;
    logic       r_rsp_ack_err;

    logic w_wrap, w_rel, w_hold, w_rd_byte, w_sda;

    assign w_wrap    = (r_cnt == CNT_W'(CLK_DIV - 1));
    assign w_rd_byte = (r_idx == 2'd3) && r_rnw;
    assign w_sda     = r_sda_s[1];

    always_comb begin
        w_rel = 1'b0;
        case (r_state)
            S_START:       w_rel = 1'b1;
            S_BYTE, S_ACK: w_rel = r_q[1];
            S_STOP:        w_rel = (r_q != 2'd0);
            default:       w_rel = 1'b0;
        endcase
    end

`ifdef I2C_CLK_STRETCH_EN
    // Only a slave can hold SCL low once our own registered pull-down is gone.
    assign w_hold = w_rel && !r_scl_oe && !bus.scl_i;
`else
    assign w_hold = 1'b0;
`endif

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_q_n     = r_q;
        w_bit_n   = r_bit;
        w_idx_n   = r_idx;
        w_shift_n = r_shift;
        w_rx_n    = r_rx;
        w_nack_n  = r_nack;
        w_dev_n   = r_dev;
        w_rnw_n   = r_rnw;
        w_reg_n   = r_reg;
        w_sub_n   = r_sub;
        w_wdata_n = r_wdata;
        case (r_state)
            S_IDLE: if (bus.cmd_valid) begin
                w_state_n = S_START;
                w_cnt_n   = '0;
                w_q_n     = 2'd0;
                w_dev_n   = bus.cmd_dev_addr;
                w_rnw_n   = bus.cmd_rnw;
                w_reg_n   = bus.cmd_reg;
                w_sub_n   = bus.cmd_sub;
                w_wdata_n = bus.cmd_wdata;
                w_shift_n = {bus.cmd_dev_addr, bus.cmd_rnw};
                w_nack_n  = 1'b0;
                w_rx_n    = 8'h00;
            end
            S_DONE: w_state_n = S_IDLE;
            default: if (!w_hold) begin
                if (w_wrap) begin
                    w_cnt_n = '0;
                    w_q_n   = r_q + 2'd1;
                    case (r_state)
                        S_START: if (r_q == 2'd3) begin
                            w_state_n = S_BYTE;
                            w_bit_n   = 3'd7;
                            w_idx_n   = 2'd0;
                        end
                        S_BYTE: begin
                            if (r_q == 2'd2 && w_rd_byte) w_rx_n = {r_rx[6:0], w_sda};
                            if (r_q == 2'd3) begin
                                if (r_bit == 3'd0) begin
                                    w_state_n = S_ACK;
                                end else begin
                                    w_bit_n   = r_bit - 3'd1;
                                    w_shift_n = {r_shift[6:0], 1'b0};
                                end
                            end
                        end
                        S_ACK: begin
                            // The ACK after the read byte is ours (a NACK), not the slave's.
                            if (r_q == 2'd2 && !w_rd_byte && w_sda) w_nack_n = 1'b1;
                            if (r_q == 2'd3) begin
                                if (r_nack || r_idx == 2'd3) begin
                                    w_state_n = S_STOP;
                                end else begin
                                    w_state_n = S_BYTE;
                                    w_idx_n   = r_idx + 2'd1;
                                    w_bit_n   = 3'd7;
                                    case (r_idx)
                                        2'd0:    w_shift_n = r_reg;
                                        2'd1:    w_shift_n = r_sub;
                                        default: w_shift_n = r_wdata;
                                    endcase
                                end
                            end
                        end
                        S_STOP: if (r_q == 2'd3) w_state_n = S_DONE;
                        default: ;
                    endcase
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        w_scl_oe_n = 1'b0;
        w_sda_oe_n = 1'b0;
        case (r_state)
            S_START: w_sda_oe_n = r_q[1];
            S_BYTE: begin
                w_scl_oe_n = !r_q[1];
                w_sda_oe_n = !w_rd_byte && !r_shift[7];
            end
            S_ACK:   w_scl_oe_n = !r_q[1];
            S_STOP: begin
                w_scl_oe_n = (r_q == 2'd0);
                w_sda_oe_n = (r_q <= 2'd1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_q           <= 2'd0;
            r_bit         <= 3'd0;
            r_idx         <= 2'd0;
            r_shift       <= 8'h00;
            r_rx          <= 8'h00;
            r_nack        <= 1'b0;
            r_dev         <= 7'h00;
            r_rnw         <= 1'b0;
            r_reg         <= 8'h00;
            r_sub         <= 8'h00;
            r_wdata       <= 8'h00;
            r_scl_oe      <= 1'b0;
            r_sda_oe      <= 1'b0;
            r_sda_s       <= 2'b11;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= 8'h00;
            r_rsp_ack_err <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_q         <= w_q_n;
            r_bit       <= w_bit_n;
            r_idx       <= w_idx_n;
            r_shift     <= w_shift_n;
            r_rx        <= w_rx_n;
            r_nack      <= w_nack_n;
            r_dev       <= w_dev_n;
            r_rnw       <= w_rnw_n;
            r_reg       <= w_reg_n;
            r_sub       <= w_sub_n;
            r_wdata     <= w_wdata_n;
            r_scl_oe    <= w_scl_oe_n;
            r_sda_oe    <= w_sda_oe_n;
            r_sda_s     <= {r_sda_s[0], bus.sda_i};
            r_rsp_valid <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                r_rsp_rdata   <= (r_rnw && !r_nack) ? r_rx : 8'h00;
                r_rsp_ack_err <= r_nack;
            end
        end
    end

    assign bus.cmd_ready   = (r_state == S_IDLE);
    assign bus.busy        = (r_state != S_IDLE) && (r_state != S_DONE);
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_ack_err = r_rsp_ack_err;
    assign bus.scl_oe      = r_scl_oe;
    assign bus.sda_oe      = r_sda_oe;
endmodule

// File: tb/tb_i2c_codec_master.sv
// Directed bench for i2c_codec_master with an open-drain codec slave model.
module tb_i2c_codec_master;
    localparam int CLK_DIV = 4;
    localparam int LAT_FULL = 152 * CLK_DIV + 1;
    localparam int LAT_NACK = 44 * CLK_DIV + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_codec_master_if bus();

    i2c_codec_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic       sl_sda_low = 1'b0;
    logic       sl_scl_hold = 1'b0;
    logic       sl_present = 1'b1;
    logic       stretch_on = 1'b0;
    logic [7:0] sl_rdata = 8'h00;
    int         k = 0;
    int         stops = 0;
    logic       cap [0:39];

    wire scl_w = !(bus.scl_oe || sl_scl_hold);
    wire sda_w = !(bus.sda_oe || sl_sda_low);
    assign bus.scl_i = scl_w;
    assign bus.sda_i = sda_w;

    always @(negedge sda_w) if (scl_w === 1'b1) k = 0;
    always @(posedge sda_w) if (scl_w === 1'b1) stops++;
    always @(posedge scl_w) begin
        if (k >= 0 && k < 40) cap[k] = sda_w;
        k++;
    end

    // Slave drives SDA only while SCL is low; direction comes from the captured R/W bit.
    always @(negedge scl_w) begin
        int b, p;
        b = k / 9;
        p = k % 9;
        sl_sda_low = 1'b0;
        if (sl_present) begin
            if (p == 8 && (b < 3 || (b == 3 && cap[7] !== 1'b1))) sl_sda_low = 1'b1;
            else if (b == 3 && cap[7] === 1'b1 && p < 8) sl_sda_low = !sl_rdata[7-p];
        end
        if (stretch_on && k == 17) begin
            int n;
            sl_scl_hold = 1'b1;
            n = 0;
            while (bus.scl_oe !== 1'b0 && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            repeat (50) @(posedge clk);
            #1 sl_scl_hold = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] cap_byte(input int b);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[7-i] = cap[9*b+i];
        return v;
    endfunction

    function automatic logic [3:0] cap_acks();
        return {cap[8], cap[17], cap[26], cap[35]};
    endfunction

    task automatic issue(input logic [6:0] d, input logic rnw, input logic [7:0] r, s, w,
                         input bit keep);
        for (int i = 0; i < 2000 && bus.cmd_ready !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        bus.cmd_dev_addr = d;
        bus.cmd_rnw      = rnw;
        bus.cmd_reg      = r;
        bus.cmd_sub      = s;
        bus.cmd_wdata    = w;
        bus.cmd_valid    = 1'b1;
        @(posedge clk); #1;
        if (!keep) bus.cmd_valid = 1'b0;
    endtask

    int         lat;
    logic [7:0] got_rdata;
    logic       got_err;

    task automatic wait_rsp(input int budget);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid === 1'b1) begin
                lat       = i;
                got_rdata = bus.rsp_rdata;
                got_err   = bus.rsp_ack_err;
                break;
            end
        end
    endtask

    initial begin
        int s0, seen;
        bus.cmd_valid = 1'b0;
        bus.cmd_dev_addr = 7'h00;
        bus.cmd_rnw = 1'b0;
        bus.cmd_reg = 8'h00;
        bus.cmd_sub = 8'h00;
        bus.cmd_wdata = 8'h00;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl_oe", bus.scl_oe, 0);
        chk("rst_sda_oe", bus.sda_oe, 0);
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rdata", bus.rsp_rdata, 0);
        chk("rst_ack_err", bus.rsp_ack_err, 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Write with all ACKs
        s0 = stops;
        issue(7'h1A, 1'b0, 8'h02, 8'h10, 8'h5C, 0);
        chk("wr_ready_drop", bus.cmd_ready, 0);
        chk("wr_busy", bus.busy, 1);
        wait_rsp(2000);
        chk("wr_latency", lat, LAT_FULL);
        chk("wr_b0", cap_byte(0), 8'h34);
        chk("wr_b1", cap_byte(1), 8'h02);
        chk("wr_b2", cap_byte(2), 8'h10);
        chk("wr_b3", cap_byte(3), 8'h5C);
        chk("wr_acks", cap_acks(), 4'h0);
        chk("wr_rdata", got_rdata, 0);
        chk("wr_ack_err", got_err, 0);
        chk("wr_stop", stops - s0, 1);
        chk("wr_busy_at_rsp", bus.busy, 0);
        @(posedge clk); #1;
        chk("wr_rsp_pulse", bus.rsp_valid, 0);
        chk("wr_ready_back", bus.cmd_ready, 1);

        // Read, slave returns 0xA5
        s0 = stops;
        sl_rdata = 8'hA5;
        issue(7'h1A, 1'b1, 8'h02, 8'h10, 8'h00, 0);
        wait_rsp(2000);
        chk("rd_latency", lat, LAT_FULL);
        chk("rd_b0", cap_byte(0), 8'h35);
        chk("rd_b3", cap_byte(3), 8'hA5);
        chk("rd_master_nack", cap[35], 1);
        chk("rd_rdata", got_rdata, 8'hA5);
        chk("rd_ack_err", got_err, 0);
        chk("rd_stop", stops - s0, 1);

        // No slave: NACK on the address byte
        s0 = stops;
        sl_present = 1'b0;
        issue(7'h1A, 1'b0, 8'h02, 8'h10, 8'h5C, 0);
        wait_rsp(2000);
        chk("nack_latency", lat, LAT_NACK);
        chk("nack_ack_err", got_err, 1);
        chk("nack_rdata", got_rdata, 0);
        chk("nack_scl_rises", k, 10);
        chk("nack_stop", stops - s0, 1);
        sl_present = 1'b1;

        // Back-to-back with fields changing after the first accept
        issue(7'h1A, 1'b0, 8'h02, 8'h10, 8'h5C, 1);
        bus.cmd_dev_addr = 7'h2B;
        bus.cmd_reg = 8'h33;
        bus.cmd_sub = 8'h44;
        bus.cmd_wdata = 8'h66;
        wait_rsp(2000);
        chk("b2b_lat1", lat, LAT_FULL);
        chk("b2b_1_b0", cap_byte(0), 8'h34);
        chk("b2b_1_b3", cap_byte(3), 8'h5C);
        chk("b2b_busy_at_rsp", bus.busy, 0);
        @(posedge clk); #1;
        chk("b2b_accept_next", bus.busy, 1);
        bus.cmd_valid = 1'b0;
        wait_rsp(2000);
        chk("b2b_lat2", lat, LAT_FULL);
        chk("b2b_2_b0", cap_byte(0), 8'h56);
        chk("b2b_2_b1", cap_byte(1), 8'h33);
        chk("b2b_2_b2", cap_byte(2), 8'h44);
        chk("b2b_2_b3", cap_byte(3), 8'h66);

        // Reset during the register byte
        issue(7'h1A, 1'b0, 8'h02, 8'h10, 8'h5C, 0);
        for (int i = 0; i < 2000 && !(k >= 12 && bus.scl_oe === 1'b1); i++) begin
            @(posedge clk); #1;
        end
        chk("rmid_reached", (k >= 12 && bus.scl_oe === 1'b1), 1);
        rst_n = 1'b0;
        #1;
        chk("rmid_scl_oe", bus.scl_oe, 0);
        chk("rmid_sda_oe", bus.sda_oe, 0);
        chk("rmid_busy", bus.busy, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 700; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid === 1'b1) seen++;
        end
        chk("rmid_no_rsp", seen, 0);
        issue(7'h1A, 1'b0, 8'h02, 8'h10, 8'h5C, 0);
        wait_rsp(2000);
        chk("rmid_fresh_lat", lat, LAT_FULL);
        chk("rmid_fresh_b1", cap_byte(1), 8'h02);
        chk("rmid_fresh_err", got_err, 0);

`ifdef I2C_CLK_STRETCH_EN
        // Slave stretches the register-byte ACK by 50 cycles
        stretch_on = 1'b1;
        issue(7'h1A, 1'b0, 8'h02, 8'h10, 8'h5C, 0);
        wait_rsp(3000);
        stretch_on = 1'b0;
        chk("str_latency", lat, LAT_FULL + 50);
        chk("str_b0", cap_byte(0), 8'h34);
        chk("str_b1", cap_byte(1), 8'h02);
        chk("str_b2", cap_byte(2), 8'h10);
        chk("str_b3", cap_byte(3), 8'h5C);
        chk("str_acks", cap_acks(), 4'h0);
        chk("str_ack_err", got_err, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
